// File: rtl/reverb_pkg.sv
`default_nettype none
// ============================================================================
// reverb_pkg -- shared state encoding, gain format and saturation helper
// Revision: 1.0
// ============================================================================
package reverb_pkg;

   localparam int GAIN_FRAC_BITS = 4;
   localparam int SAT_W          = 64;

   typedef enum logic [2:0] {
      ST_CLEAR = 3'd0,
      ST_IDLE  = 3'd1,
      ST_WRITE = 3'd2,
      ST_TAPS  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // Clamp a wide signed value into the signed range of 'width' bits.
   function automatic logic signed [SAT_W-1:0] saturate(
      input logic signed [SAT_W-1:0] value,
      input int                      width
   );
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      logic signed [SAT_W-1:0] result;
      max_v  = $signed({1'b0, {(SAT_W-1){1'b1}}} >> (SAT_W - width));
      min_v  = ~max_v;
      result = value;
      if (value > max_v) begin
         result = max_v;
      end else if (value < min_v) begin
         result = min_v;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reverb_tap_mac.sv
`default_nettype none
// ============================================================================
// reverb_tap_mac -- gain multiply, fractional shift and wide accumulate
// Revision: 1.0
// ============================================================================
module reverb_tap_mac
   import reverb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = DATA_WIDTH + GAIN_FRAC_BITS
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         init,
   input  logic signed [DATA_WIDTH-1:0] init_value,
   input  logic                         acc_en,
   input  logic signed [DATA_WIDTH-1:0] sample,
   input  logic [3:0]                   gain,
   input  logic                         tap_on,
   output logic signed [ACC_WIDTH-1:0]  acc
);
   localparam int PROD_W = DATA_WIDTH + 5;

   logic signed [PROD_W-1:0]    product;
   logic signed [PROD_W-1:0]    scaled;
   logic signed [ACC_WIDTH-1:0] contrib;

   // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
   always_comb begin
      product = PROD_W'(sample) * PROD_W'($signed({1'b0, gain}));
      scaled  = product >>> GAIN_FRAC_BITS;
      contrib = tap_on ? ACC_WIDTH'(scaled) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (init) begin
         acc <= ACC_WIDTH'(init_value);
      end else if (acc_en) begin
         acc <= acc + contrib;
      end
   end

endmodule
`default_nettype wire

// File: rtl/reverb_tap_scheduler.sv
`default_nettype none
// ============================================================================
// reverb_tap_scheduler -- multi-tap echo scheduler over a single-port delay RAM
// Revision: 1.0
// ============================================================================
module reverb_tap_scheduler
   import reverb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int NUM_TAPS   = 4
)(
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic [NUM_TAPS*ADDR_WIDTH-1:0] tap_delay,
   input  logic [NUM_TAPS*4-1:0]          tap_gain,
   input  logic [NUM_TAPS-1:0]            tap_en,
   output logic [ADDR_WIDTH-1:0]          mem_addr,
   output logic                           mem_we,
   output logic [DATA_WIDTH-1:0]          mem_wdata,
   input  logic [DATA_WIDTH-1:0]          mem_rdata,
   output logic                           out_valid,
   output logic [DATA_WIDTH-1:0]          out_data
);
   localparam int               IDX_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam int               ACC_W    = DATA_WIDTH + GAIN_FRAC_BITS;
   localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);

   state_t                         state;
   state_t                         next_state;
   logic [ADDR_WIDTH-1:0]          clear_addr;
   logic [ADDR_WIDTH-1:0]          wr_ptr;
   logic [ADDR_WIDTH-1:0]          base_addr;
   logic [ADDR_WIDTH-1:0]          cur_delay;
   logic [IDX_W-1:0]               tap_idx;
   logic [IDX_W-1:0]               rd_idx;
   logic                           rd_valid;
   logic                           rd_on;
   logic [3:0]                     rd_gain;
   logic                           accept;
   logic                           we_raw;
   logic [DATA_WIDTH-1:0]          sample;
   logic [DATA_WIDTH-1:0]          sat_data;
   logic [DATA_WIDTH-1:0]          data_hold;
   logic [NUM_TAPS*ADDR_WIDTH-1:0] lat_delay;
   logic [NUM_TAPS*4-1:0]          lat_gain;
   logic [NUM_TAPS-1:0]            lat_en;
   logic signed [ACC_W-1:0]        acc;

   assign accept    = in_valid && in_ready;
   assign cur_delay = lat_delay[tap_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign rd_gain   = lat_gain[rd_idx*4 +: 4];
   assign rd_on     = lat_en[rd_idx];
   assign sat_data  = DATA_WIDTH'(saturate(SAT_W'(acc), DATA_WIDTH));

   always_comb begin
      next_state = state;
      we_raw     = 1'b0;
      mem_addr   = wr_ptr;
      mem_wdata  = '0;
      case (state)
         ST_CLEAR: begin
            we_raw   = 1'b1;
            mem_addr = clear_addr;
            if (clear_addr == '1) next_state = ST_IDLE;
         end
         ST_IDLE: begin
            if (accept) next_state = ST_WRITE;
         end
         ST_WRITE: begin
            we_raw     = 1'b1;
            mem_wdata  = sample;
            next_state = ST_TAPS;
         end
         ST_TAPS: begin
            // Unsigned subtraction wraps modulo the delay-line depth.
            mem_addr = base_addr - cur_delay;
            if (tap_idx == LAST_TAP) next_state = ST_DRAIN;
         end
         ST_DRAIN: next_state = ST_DONE;
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_CLEAR;
      endcase
   end

   assign mem_we    = we_raw && !reset_n;
   assign out_valid = (state == ST_DONE);
   assign out_data  = out_valid ? sat_data : data_hold;

   always_ff @(posedge clk) begin
      if (reset_n) begin
         state      <= ST_CLEAR;
         clear_addr <= '0;
         wr_ptr     <= '0;
         base_addr  <= '0;
         in_ready   <= 1'b0;
         tap_idx    <= '0;
         rd_idx     <= '0;
         rd_valid   <= 1'b0;
         data_hold  <= '0;
         sample     <= '0;
         lat_delay  <= '0;
         lat_gain   <= '0;
         lat_en     <= '0;
      end else begin
         state    <= next_state;
         in_ready <= (next_state == ST_IDLE);
         // Read data lags its address by one cycle; track which tap it belongs to.
         rd_valid <= (state == ST_TAPS);
         rd_idx   <= tap_idx;
         if (state == ST_CLEAR) clear_addr <= clear_addr + ADDR_WIDTH'(1);
         if (accept) begin
            sample    <= in_data;
            lat_delay <= tap_delay;
            lat_gain  <= tap_gain;
            lat_en    <= tap_en;
         end
         if (state == ST_WRITE) begin
            base_addr <= wr_ptr;
            wr_ptr    <= wr_ptr + ADDR_WIDTH'(1);
            tap_idx   <= '0;
         end
         if (state == ST_TAPS) tap_idx <= tap_idx + IDX_W'(1);
         if (state == ST_DONE) data_hold <= sat_data;
      end
   end

   reverb_tap_mac #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mac (
      .clk        (clk),
      .rst        (reset_n),
      .init       (accept),
      .init_value (in_data),
      .acc_en     (rd_valid),
      .sample     (mem_rdata),
      .gain       (rd_gain),
      .tap_on     (rd_on),
      .acc        (acc)
   );

endmodule
`default_nettype wire

// File: tb/tb_reverb_tap_scheduler.sv
`default_nettype none
// ============================================================================
// tb_reverb_tap_scheduler -- randomized bench with a sample-history reference model
// Revision: 1.0
// ============================================================================
module tb_reverb_tap_scheduler;
   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int NT    = 4;
   localparam int DEPTH = 16;

   logic          clk       = 1'b0;
   logic          reset_n   = 1'b1;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data   = '0;
   logic [15:0]   tap_delay = '0;
   logic [15:0]   tap_gain  = '0;
   logic [3:0]    tap_en    = '0;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          out_valid;
   logic [DW-1:0] out_data;

   logic [DW-1:0] ram [DEPTH];
   int            checks = 0;
   int            errors = 0;
   longint        hist[$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   reverb_tap_scheduler #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_TAPS   (NT)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .tap_delay (tap_delay),
      .tap_gain  (tap_gain),
      .tap_en    (tap_en),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   // Wet sample n = dry + sum of enabled floor(history[n-delay]*gain/16); pre-history is silence.
   function automatic logic [31:0] model_out(input int n, input logic [15:0] dl,
                                             input logic [15:0] gn, input logic [3:0] en);
      longint acc;
      acc = hist[n];
      for (int i = 0; i < NT; i++) begin
         if (en[i]) begin
            int     idx;
            longint v;
            idx = n - int'(dl[i*4 +: 4]);
            v   = (idx >= 0) ? hist[idx] : 64'sd0;
            acc += (v * longint'(gn[i*4 +: 4])) >>> 4;
         end
      end
      if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (acc < -64'sd2147483648) return 32'h8000_0000;
      return acc[31:0];
   endfunction

   task automatic apply_reset();
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
      reset_n = 1'b0;
      #1;
      for (int c = 1; c <= 16; c++) begin
         if (c > 1) @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== AW'(c - 1) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_cycle%0d: ready=%b we=%b addr=%0d ov=%b want ready=0 we=1 addr=%0d ov=0",
                     c, in_ready, mem_we, mem_addr, out_valid, c - 1);
         end
      end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clear_done_ready: got %b want 1", in_ready); end
      hist.delete();
   endtask

   task automatic send_sample(input logic [31:0] d, input logic [15:0] dl, input logic [15:0] gn,
                              input logic [3:0] en, output logic [31:0] got);
      int         n;
      int         waits;
      logic [31:0] exp;
      logic [3:0]  wa;
      logic [3:0]  ea;
      got = 'x;
      in_valid = 1'b1; in_data = d; tap_delay = dl; tap_gain = gn; tap_en = en;
      waits = 0;
      while (in_ready !== 1'b1 && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (in_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
         in_valid = 1'b0;
         return;
      end
      n = hist.size();
      hist.push_back(longint'($signed(d)));
      exp = model_out(n, dl, gn, en);
      wa  = n[3:0];
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in_data = $urandom;
      tap_delay = 16'($urandom); tap_gain = 16'($urandom); tap_en = 4'($urandom);
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) @(negedge clk);
         if (k == 3) tap_gain = 16'($urandom);
         checks++;
         if (out_valid !== 1'(k == 7)) begin
            errors++; $display("FAIL out_valid_k%0d: got %b want %b", k, out_valid, k == 7);
         end
         if (k == 1) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== wa || mem_wdata !== d) begin
               errors++;
               $display("FAIL write_n%0d: we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                        n, mem_we, mem_addr, mem_wdata, wa, d);
            end
         end
         if (k >= 2 && k <= 5) begin
            ea = wa - dl[(k-2)*4 +: 4];
            checks++;
            if (mem_we !== 1'b0 || mem_addr !== ea) begin
               errors++;
               $display("FAIL tap%0d_addr_n%0d: we=%b addr=%0d want we=0 addr=%0d", k - 2, n, mem_we, mem_addr, ea);
            end
         end
         if (k == 7) begin
            got = out_data;
            checks++;
            if (out_data !== exp) begin
               errors++; $display("FAIL out_data_n%0d: got %h want %h", n, out_data, exp);
            end
            checks++;
            if (in_ready !== 1'b0) begin
               errors++; $display("FAIL ready_during_out_n%0d: got %b want 0", n, in_ready);
            end
         end
         if (k == 8) begin
            checks++;
            if (in_ready !== 1'b1 || out_data !== exp) begin
               errors++;
               $display("FAIL after_out_n%0d: ready=%b data=%h want ready=1 data=%h", n, in_ready, out_data, exp);
            end
         end
      end
   endtask

   task automatic test_reset();
      in_valid = 1'b1; in_data = '0; tap_en = '0;
      apply_reset();
   endtask

   task automatic test_impulse();
      int          exp_imp[5] = '{1000, 0, 0, 500, 0};
      logic [31:0] got;
      for (int i = 0; i < 5; i++) begin
         send_sample((i == 0) ? 32'd1000 : 32'd0, 16'h0003, 16'h0008, 4'b0001, got);
         checks++;
         if (got !== 32'(exp_imp[i])) begin
            errors++; $display("FAIL impulse_%0d: got %0d want %0d", i, $signed(got), exp_imp[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] got;
      for (int i = 0; i < 20; i++) begin
         send_sample($urandom, {12'($urandom), 4'hF}, 16'($urandom), 4'($urandom) | 4'b0001, got);
      end
   endtask

   task automatic test_saturation();
      logic [31:0] got;
      logic [31:0] vals[2] = '{32'h7FFF_FFF0, 32'h8000_0000};
      logic [31:0] lims[2] = '{32'h7FFF_FFFF, 32'h8000_0000};
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 4; i++) send_sample(vals[s], 16'h4321, 16'hFFFF, 4'b0000, got);
         send_sample(vals[s], 16'h4321, 16'hFFFF, 4'b1111, got);
         checks++;
         if (got !== lims[s]) begin
            errors++; $display("FAIL saturate_%0d: got %h want %h", s, got, lims[s]);
         end
      end
   endtask

   task automatic test_gain_change();
      logic [31:0] got;
      logic [15:0] g1;
      for (int i = 0; i < 3; i++) begin
         g1 = 16'($urandom);
         send_sample($urandom, 16'($urandom), g1, 4'b1111, got);
         send_sample($urandom, 16'($urandom), ~g1, 4'b1111, got);
      end
   endtask

   task automatic test_reset_mid();
      int waits;
      logic [31:0] got;
      in_valid = 1'b1; in_data = 32'h1234_5678; tap_delay = 16'h0000; tap_gain = 16'hFFFF; tap_en = 4'hF;
      waits = 0;
      while (in_ready !== 1'b1 && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_accept_timeout: in_ready=%b want 1", in_ready); end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      apply_reset();
      send_sample(32'd777, 16'h0000, 16'h0000, 4'b0000, got);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_impulse();
      test_wrap();
      test_saturation();
      test_gain_change();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reverb_tap_scheduler.md
REVERB_TAP_SCHEDULER -- requirements
Module: reverb_tap_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: signed two's-complement audio sample width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: delay-line RAM address width; depth is 2^ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_TAPS, default 4: number of echo taps per sample.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: dry sample present.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a sample.
REQ-008 SHALL have port in_data, input, DATA_WIDTH bits: dry sample.
REQ-009 SHALL have port tap_delay, input, NUM_TAPS*ADDR_WIDTH bits: per-tap delay in samples; tap i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port tap_gain, input, NUM_TAPS*4 bits: per-tap unsigned gain, interpreted as gain/16.
REQ-011 SHALL have port tap_en, input, NUM_TAPS bits: per-tap enable.
REQ-012 SHALL have port mem_addr, output, ADDR_WIDTH bits: RAM address.
REQ-013 SHALL have port mem_we, output, 1 bit: RAM write enable.
REQ-014 SHALL have port mem_wdata, output, DATA_WIDTH bits: RAM write data.
REQ-015 SHALL have port mem_rdata, input, DATA_WIDTH bits: RAM read data, valid exactly 1 cycle after the address is presented.
REQ-016 SHALL have port out_valid, output, 1 bit: single-cycle pulse marking a new wet sample.
REQ-017 SHALL have port out_data, output, DATA_WIDTH bits: wet sample, held until the next out_valid.

Function
REQ-018 FSM states SHALL be CLEAR, IDLE, WRITE, TAPS, DRAIN, DONE.
REQ-019 CLEAR SHALL write 0 to addresses 0..2^ADDR_WIDTH-1, one per cycle with mem_we=1, then go to IDLE.
REQ-020 in_ready SHALL be 1 only in IDLE; a sample is accepted on the cycle where in_valid && in_ready.
REQ-021 On acceptance, in_data, tap_delay, tap_gain and tap_en SHALL be latched; config changes after acceptance do not affect that sample.
REQ-022 WRITE SHALL last 1 cycle: mem_we=1, mem_addr=wr_ptr, mem_wdata=latched sample; wr_ptr then increments modulo 2^ADDR_WIDTH.
REQ-023 TAPS SHALL last NUM_TAPS cycles, issuing tap i on cycle i with mem_addr = (write address - delay_i) mod 2^ADDR_WIDTH and mem_we=0.
REQ-024 delay_i=0 SHALL return the current sample; wrap-around below address 0 SHALL be modulo depth.
REQ-025 DRAIN SHALL last 1 cycle and accumulate the last tap; each mem_rdata SHALL be accumulated the cycle it is valid.
REQ-026 Tap contribution SHALL be (mem_rdata * gain_i) arithmetically shifted right by 4; a disabled tap contributes 0 but still consumes its cycle (fixed latency).
REQ-027 The accumulator SHALL start at the dry sample, be DATA_WIDTH+4 bits signed, and have no intermediate saturation.
REQ-028 DONE SHALL saturate the accumulator to the signed DATA_WIDTH range into out_data, assert out_valid for 1 cycle, then go to IDLE.
REQ-029 Latency SHALL be NUM_TAPS+3 cycles from acceptance to out_valid; in_ready SHALL return to 1 the cycle after out_valid.
REQ-030 in_valid while in_ready=0 SHALL be ignored; the source holds the sample.

Reset
REQ-031 When reset_n=1 at a clock edge: state=CLEAR, clear address=0, wr_ptr=0, in_ready=0, out_valid=0, out_data=0, mem_we=0, accumulator=0.
REQ-032 Reset mid-operation SHALL discard the in-flight sample with no out_valid and restart CLEAR.

Structure
REQ-033 A shared package reverb_pkg SHALL hold the state encoding, GAIN_FRAC_BITS=4 and the saturation function.
REQ-034 A single sub-module reverb_tap_mac SHALL implement the gain multiply, shift and accumulate.

Verification (ADDR_WIDTH=4, NUM_TAPS=4)
REQ-035 Reset, then hold in_valid=1: in_ready=0 for 16 CLEAR cycles with mem_we=1 and addr 0..15 -> in_ready=1 on cycle 17.
REQ-036 Impulse 1000 then zeros; tap0 delay=3, gain=8, others disabled -> outputs 1000,0,0,500,0…, each out_valid exactly 7 cycles after acceptance.
REQ-037 Twenty samples with delay=15 -> read address wraps correctly (write addr 2 reads addr 3); output matches the reference model.
REQ-038 Dry=0x7FFFFFF0, four taps at gain=15 on same-value history -> out_data=0x7FFFFFFF; negative case -> 0x80000000.
REQ-039 Change tap_gain while in TAPS -> current output uses the latched gain; the next sample uses the new one.
REQ-040 Assert reset during TAPS -> no out_valid; CLEAR restarts at address 0.
